// File: rtl/regfile.sv
// regfile: RV32I integer register file, 32 x 32-bit, x0 hardwired to zero.
// Two combinational read ports (rs1, rs2) for decode, one synchronous write
// port (rd) for writeback. Synchronous active-high reset clears every register.
// Optional feature macro: REGFILE_BYPASS_EN enables write-through forwarding
// from the rd port to a read port addressing the same register in the same cycle.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rd_wren,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);

  localparam int NREGS = 2 ** ADDR_W;

  // x0 has no storage; entries start at index 1.
  logic [DATA_W-1:0] regs_q [1:NREGS-1];
  logic [DATA_W-1:0] regs_d [1:NREGS-1];

  logic rd_valid;
  assign rd_valid = rd_wren && (rd_addr != '0);

  // Next-state of the storage: only the addressed register takes rd_data.
  always_comb begin
    for (int i = 1; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (rd_valid && (rd_addr == ADDR_W'(i))) begin
        regs_d[i] = rd_data;
      end
    end
  end

  // Storage update; reset wins over a write in the same cycle.
  always_ff @(posedge clk_i) begin
    for (int i = 1; i < NREGS; i++) begin
      if (rst_i) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read port 1: x0 reads zero, otherwise stored value (optionally forwarded).
  always_comb begin
    rs1_data = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (rs1_addr == ADDR_W'(i)) begin
        rs1_data = regs_q[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (rd_valid && !rst_i && (rs1_addr == rd_addr)) begin
      rs1_data = rd_data;
    end
`else
`endif
  end

  // Read port 2: same behaviour as port 1, decided independently.
  always_comb begin
    rs2_data = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (rs2_addr == ADDR_W'(i)) begin
        rs2_data = regs_q[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (rd_valid && !rst_i && (rs2_addr == rd_addr)) begin
      rs2_data = rd_data;
    end
`else
`endif
  end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile. Expected values are
// hand-computed constants, plus a simple pattern function for the full sweep.
module tb_regfile;

  logic        clk_i;
  logic        rst_i;
  logic        rd_wren;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  int check_count;
  int error_count;

  regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_wren  (rd_wren),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  // Free-running clock, period 10.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive every DUT input in one go, then let combinational reads settle.
  task automatic applyStimulus(input logic rst, input logic wren,
                               input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] ra1, input logic [4:0] ra2);
    rst_i    = rst;
    rd_wren  = wren;
    rd_addr  = wa;
    rd_data  = wd;
    rs1_addr = ra1;
    rs2_addr = ra2;
    #1;
  endtask

  // Advance past one rising edge and sample away from it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] sweep_val(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'h5A00_00C3;
  endfunction

  initial begin
    logic [31:0] exp_pre;
    check_count = 0;
    error_count = 0;

    // Bring the array to a defined state.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd0);
    checkOutput("init_x2", rs1_data, 32'h0);
    checkOutput("init_x0", rs2_data, 32'h0);

    // Reset after writes to x2/x3.
    applyStimulus(1'b0, 1'b1, 5'd2, 32'hDEAD_0002, 5'd2, 5'd3);
    tick();
    applyStimulus(1'b0, 1'b1, 5'd3, 32'hBEEF_0003, 5'd2, 5'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd3);
    checkOutput("pre_rst_x2", rs1_data, 32'hDEAD_0002);
    checkOutput("pre_rst_x3", rs2_data, 32'hBEEF_0003);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd3);
    checkOutput("rst_before_edge_x2", rs1_data, 32'hDEAD_0002);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd3);
    checkOutput("rst_x2", rs1_data, 32'h0);
    checkOutput("rst_x3", rs2_data, 32'h0);

    // Basic write then read.
    applyStimulus(1'b0, 1'b1, 5'd2, 32'hF, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 5'd3, 32'hA, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd3);
    checkOutput("wr_x2", rs1_data, 32'hF);
    checkOutput("wr_x3", rs2_data, 32'hA);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd3);
    checkOutput("rd_x0", rs1_data, 32'h0);

    // Write enable low leaves storage alone.
    applyStimulus(1'b0, 1'b0, 5'd2, 32'h55, 5'd2, 5'd2);
    tick();
    checkOutput("wren0_x2", rs1_data, 32'hF);

    // Overwrite x3; x2 untouched.
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h4, 5'd2, 5'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd3);
    checkOutput("ovw_x3", rs2_data, 32'h4);
    checkOutput("ovw_x2", rs1_data, 32'hF);

    // Sweep: write a distinct value to every register, read on both ports.
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(i), sweep_val(i), 5'd0, 5'd0);
      tick();
    end
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
      checkOutput($sformatf("sweep_rs1_x%0d", i), rs1_data, sweep_val(i));
      checkOutput($sformatf("sweep_rs2_x%0d", 32 - i), rs2_data, sweep_val(32 - i));
    end

    // Reset beats a simultaneous write.
    applyStimulus(1'b1, 1'b1, 5'd1, 32'hE, 5'd1, 5'd2);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    checkOutput("rstwr_x1", rs1_data, 32'h0);
    checkOutput("rstwr_x2", rs2_data, 32'h0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd31);
    checkOutput("rstwr_x3", rs1_data, 32'h0);
    checkOutput("rstwr_x31", rs2_data, 32'h0);

    // x0 is immutable, even with forwarding.
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    checkOutput("x0_pre_rs1", rs1_data, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    checkOutput("x0_rs1", rs1_data, 32'h0);
    checkOutput("x0_rs2", rs2_data, 32'h0);

    // Read-during-write of x5; port 2 looks at an unrelated register.
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'h1234;
`else
    exp_pre = 32'h0;
`endif
    applyStimulus(1'b0, 1'b1, 5'd5, 32'h1234, 5'd5, 5'd6);
    checkOutput("rdw_pre_x5", rs1_data, exp_pre);
    checkOutput("rdw_pre_x6", rs2_data, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    checkOutput("rdw_post_rs1", rs1_data, 32'h1234);
    checkOutput("rdw_post_rs2", rs2_data, 32'h1234);

    // No forwarding while reset is asserted; old contents visible until the edge.
    applyStimulus(1'b1, 1'b1, 5'd5, 32'h99, 5'd5, 5'd5);
    checkOutput("rst_nofwd_x5", rs2_data, 32'h1234);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    checkOutput("rst_clr_x5", rs1_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
